// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store.
// Load/store has priority; a streak limit guarantees fetch progress.
module mem_arbiter #(
  parameter int LS_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  load_code,
  input  logic [1:0]  store_code,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        ls_misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int SW = (LS_STREAK_MAX < 1) ? 1 : $clog2(LS_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(LS_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    LS_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;

  logic          ls_load, ls_valid, misalign, grant_ls, grant_if, acc;
  logic [1:0]    ls_size;

  logic [31:0]   addr_p0;
  logic          we_p0;
  logic [3:0]    be_p0;
  logic [31:0]   wdata_p0;
  logic [2:0]    lcode_p0;
  logic          is_ls_p0;
  logic          mis_p0;
  logic [31:0]   result_p1;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s == STREAK_TOP) ? s : s + 1'b1;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  a,
                                              input logic [2:0]  code);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (code[1:0])
      2'b00:   r = code[2] ? {24'h0, sh[7:0]}  : 32'(b);
      2'b01:   r = code[2] ? {16'h0, sh[15:0]} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] code);
    case (code)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] d, input logic [1:0] code);
    case (code)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Request decode and grant
  assign ls_load  = (load_code != 3'b111);
  assign ls_valid = ls_req & (ls_load | (store_code != 2'b11));
  assign ls_size  = ls_load ? load_code[1:0] : store_code;
  assign misalign = ((ls_size == 2'b01) & ls_addr[0]) |
                    (ls_size[1] & (ls_addr[1:0] != 2'b00));
  assign grant_ls = (state == IDLE) & ls_valid & ~(if_req & (streak == STREAK_TOP));
  assign grant_if = (state == IDLE) & if_req & ~grant_ls;
  assign acc      = (state == IF_ACC) | (state == LS_ACC);

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_nx  = misalign ? DONE : LS_ACC;
          streak_nx = if_req ? sat_inc(streak) : '0;
        end else if (grant_if) begin
          state_nx  = IF_ACC;
          streak_nx = '0;
        end
      end
      IF_ACC, LS_ACC: if (mem_ready) state_nx = DONE;
      DONE:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
    end
  end

  // Stage p0: operands captured at grant; p1: response captured on mem_ready
  always_ff @(posedge clk) begin
    if (grant_ls) begin
      addr_p0   <= ls_addr;
      we_p0     <= ~ls_load;
      be_p0     <= ls_load ? 4'b1111 : store_be(ls_addr[1:0], store_code);
      wdata_p0  <= store_wdata(ls_wdata, store_code);
      lcode_p0  <= load_code;
      is_ls_p0  <= 1'b1;
      mis_p0    <= misalign;
      result_p1 <= '0;
    end else if (grant_if) begin
      addr_p0   <= if_addr;
      we_p0     <= 1'b0;
      be_p0     <= 4'b1111;
      lcode_p0  <= 3'b010;
      is_ls_p0  <= 1'b0;
      mis_p0    <= 1'b0;
    end else if (acc & mem_ready) begin
      result_p1 <= ~is_ls_p0 ? mem_rdata :
                   we_p0     ? '0        : load_extend(mem_rdata, addr_p0[1:0], lcode_p0);
    end
  end

  // Outputs, forced to zero outside the phases where they are meaningful
  assign mem_req     = acc;
  assign mem_we      = acc & we_p0;
  assign mem_addr    = acc ? {addr_p0[31:2], 2'b00} : '0;
  assign mem_wdata   = (acc & we_p0) ? wdata_p0 : '0;
  assign mem_be      = acc ? be_p0 : '0;
  assign if_ack      = (state == DONE) & ~is_ls_p0;
  assign ls_ack      = (state == DONE) & is_ls_p0;
  assign ls_misalign = ls_ack & mis_p0;
  assign if_rdata    = if_ack ? result_p1 : '0;
  assign ls_rdata    = ls_ack ? result_p1 : '0;

endmodule
